sev_seg_decoder: RTL

//  Inverse of the seven-segment encoder: watches a scanned, active-low 8-digit

---
 rtl/sev_seg_pkg.sv | 9 +
 rtl/sev_seg_pattern_decode.sv | 20 ++
 rtl/sev_seg_decoder.sv | 78 +++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared segment table, blank pattern and decoder FSM states
package sev_seg_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} segState_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };
endpackage

// File: rtl/sev_seg_pattern_decode.sv
// sev_seg_pattern_decode: active-low segment pattern to hex nibble lookup
module sev_seg_pattern_decode
  import sev_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);
  always_comb begin
    hit = 1'b0;
    nibble = 4'h0;
    for (int n = 0; n < 16; n++)
      if (SEG_TABLE[n] == pattern) begin
        hit = 1'b1;
        nibble = 4'(n);
      end
  end
  assign blank = pattern == SEG_BLANK;
endmodule

// File: rtl/sev_seg_decoder.sv
// sev_seg_decoder: recovers hex digits and DP state from a scanned active-low seven-segment bus
module sev_seg_decoder
  import sev_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS = 8,
  localparam int IdxW = $clog2(NUM_DIGITS)
) (
  input  logic                    BrdClk,
  input  logic                    aReset,
  input  logic [NUM_DIGITS-1:0]   bDigitSel,
  input  logic [7:0]              bSegmentInput,
  output logic [4*NUM_DIGITS-1:0] bDigits,
  output logic [NUM_DIGITS-1:0]   bDigitValid,
  output logic [NUM_DIGITS-1:0]   bDpOn,
  output logic                    bUpdate,
  output logic [IdxW-1:0]         bUpdateIdx,
  output logic                    bPatternErr
);
  localparam int CntW = $clog2(STABLE_CYCLES + 1);
  logic [NUM_DIGITS-1:0] selQ;
  logic [7:0] segQ;
  logic [CntW-1:0] cnt, cntNext;
  segState_t state, stateNext;
  logic selValid, same, capture, hit, blank;
  logic [IdxW-1:0] selIdx;
  logic [3:0] nibble;
  sev_seg_pattern_decode uDecode (
    .pattern(bSegmentInput[7:1]),
    .hit(hit),
    .blank(blank),
    .nibble(nibble)
  );
  always_comb begin
    selIdx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!bDigitSel[i]) selIdx = IdxW'(i);
  end
  // The sample being taken this edge is compared with the previous sample held in selQ/segQ
  always_comb begin
    selValid = $countones(~bDigitSel) == 1;
    same = bDigitSel == selQ && bSegmentInput == segQ;
    capture = selValid && state == SETTLE && same && cnt == CntW'(STABLE_CYCLES - 1);
    stateNext = !selValid ? IDLE : capture ? HELD : (state == HELD && same) ? HELD : SETTLE;
    cntNext = !selValid ? '0
            : capture ? CntW'(STABLE_CYCLES)
            : (state == HELD && same) ? cnt
            : (state == SETTLE && same) ? cnt + 1'b1
            : CntW'(1);
  end
  always_ff @(posedge BrdClk) begin
    if (aReset) begin
      selQ <= '1;
      segQ <= '1;
      state <= IDLE;
      cnt <= '0;
      bDigits <= '0;
      bDigitValid <= '0;
      bDpOn <= '0;
      bUpdate <= 1'b0;
      bUpdateIdx <= '0;
      bPatternErr <= 1'b0;
    end else begin
      selQ <= bDigitSel;
      segQ <= bSegmentInput;
      state <= stateNext;
      cnt <= cntNext;
      bUpdate <= capture;
      bPatternErr <= capture && !hit && !blank;
      if (capture) begin
        bUpdateIdx <= selIdx;
        bDpOn[selIdx] <= ~bSegmentInput[0];
        bDigitValid[selIdx] <= hit;
        if (hit) bDigits[selIdx*4 +: 4] <= nibble;
      end
    end
  end
endmodule
